fir_stim_gen: RTL

Test-signal source that drives the 32-bit sample input of the team's FIR filter blocks (sfix32, one sample per fclk).
- Generates impulse, step, square or ramp sequences of programmable length, amplitude and sample rate.
- Appends a zero-valued flush tail so the filter's delay line and output register drain before completion.
- Used on-chip for filter bring-up and for regression against software golden responses.

---
 rtl/fir_stim_gen.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/fir_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fir_stim_gen
//  Purpose  : Test-signal source for the FIR filter sample input. Produces
//             impulse / step / square / ramp sequences with programmable
//             length, amplitude and sample rate, followed by a zero-valued
//             flush tail that drains the filter delay line and output reg.
//  Revision : 1.0  initial release
// ============================================================================
module fir_stim_gen #(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int FLUSH_LEN = 10
) (
    input  logic                     fclk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic signed [DATA_W-1:0] amplitude,
    input  logic [LEN_W-1:0]         length,
    input  logic [LEN_W-1:0]         half_period,
    input  logic [LEN_W-1:0]         rate_div,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_valid,
    output logic [LEN_W-1:0]         sample_idx,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0] c_MODE_IMPULSE = 2'd0;
    localparam logic [1:0] c_MODE_STEP    = 2'd1;
    localparam logic [1:0] c_MODE_SQUARE  = 2'd2;
    localparam logic [1:0] c_MODE_RAMP    = 2'd3;

    localparam logic [LEN_W-1:0] c_FLUSH_LAST = LEN_W'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state, w_state;
    logic [1:0]                 r_mode, w_mode;
    logic signed [DATA_W-1:0]   r_amp, w_amp;
    logic [LEN_W-1:0]           r_len, w_len;
    logic [LEN_W-1:0]           r_hp, w_hp;       // effective half period, never 0
    logic [LEN_W-1:0]           r_rate, w_rate;
    logic [LEN_W-1:0]           r_div, w_div;     // fclk cycles within a sample period
    logic [LEN_W-1:0]           r_k, w_k;         // index of the stimulus sample on the output
    logic [LEN_W-1:0]           r_fcnt, w_fcnt;   // index of the flush sample on the output
    logic [LEN_W-1:0]           r_hcnt, w_hcnt;   // square: position of the NEXT sample in its half
    logic                       r_neg, w_neg;     // square: polarity of the NEXT sample
    logic signed [DATA_W-1:0]   r_acc, w_acc;     // ramp: value of the NEXT sample
    logic signed [DATA_W-1:0]   r_sample, w_sample;
    logic                       r_valid, w_valid;
    logic [LEN_W-1:0]           r_idx, w_idx;
    logic                       r_busy, w_busy;
    logic                       r_done, w_done;

    logic                       w_tick;
    logic signed [DATA_W-1:0]   w_neg_amp;

    // Sample-period boundary and the truncated negation used by the square wave
    assign w_tick    = (r_div == r_rate);
    assign w_neg_amp = -r_amp;

    // State and output registers; reset aborts any run without a done pulse
    always_ff @(posedge fclk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mode   <= '0;
            r_amp    <= '0;
            r_len    <= '0;
            r_hp     <= '0;
            r_rate   <= '0;
            r_div    <= '0;
            r_k      <= '0;
            r_fcnt   <= '0;
            r_hcnt   <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_mode   <= w_mode;
            r_amp    <= w_amp;
            r_len    <= w_len;
            r_hp     <= w_hp;
            r_rate   <= w_rate;
            r_div    <= w_div;
            r_k      <= w_k;
            r_fcnt   <= w_fcnt;
            r_hcnt   <= w_hcnt;
            r_neg    <= w_neg;
            r_acc    <= w_acc;
            r_sample <= w_sample;
            r_valid  <= w_valid;
            r_idx    <= w_idx;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    // Next-state and next-output logic; sample values are computed one tick ahead
    always_comb begin
        w_state  = r_state;
        w_mode   = r_mode;
        w_amp    = r_amp;
        w_len    = r_len;
        w_hp     = r_hp;
        w_rate   = r_rate;
        w_div    = r_div;
        w_k      = r_k;
        w_fcnt   = r_fcnt;
        w_hcnt   = r_hcnt;
        w_neg    = r_neg;
        w_acc    = r_acc;
        w_sample = r_sample;
        w_valid  = 1'b0;
        w_idx    = r_idx;
        w_busy   = r_busy;
        w_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_mode  = mode;
                    w_amp   = amplitude;
                    w_len   = length;
                    w_hp    = (half_period == '0) ? LEN_W'(1) : half_period;
                    w_rate  = rate_div;
                    w_div   = '0;
                    w_k     = '0;
                    w_fcnt  = '0;
                    w_idx   = '0;
                    w_valid = 1'b1;
                    w_busy  = 1'b1;
                    // Sample 0 of the square wave is positive; prepare sample 1's phase
                    if (w_hp == LEN_W'(1)) begin
                        w_hcnt = '0;
                        w_neg  = 1'b1;
                    end else begin
                        w_hcnt = LEN_W'(1);
                        w_neg  = 1'b0;
                    end
                    w_acc = amplitude;
                    if (length == '0) begin
                        w_state  = S_FLUSH;
                        w_sample = '0;
                    end else begin
                        w_state  = S_RUN;
                        w_sample = (mode == c_MODE_RAMP) ? '0 : amplitude;
                    end
                end
            end

            S_RUN: begin
                if (w_tick) begin
                    w_div   = '0;
                    w_valid = 1'b1;
                    w_idx   = r_idx + LEN_W'(1);
                    if (r_k == r_len - LEN_W'(1)) begin
                        w_state  = S_FLUSH;
                        w_sample = '0;
                        w_fcnt   = '0;
                    end else begin
                        w_k = r_k + LEN_W'(1);
                        case (r_mode)
                            c_MODE_IMPULSE: w_sample = '0;
                            c_MODE_STEP:    w_sample = r_amp;
                            c_MODE_SQUARE: begin
                                w_sample = r_neg ? w_neg_amp : r_amp;
                                if (r_hcnt + LEN_W'(1) == r_hp) begin
                                    w_hcnt = '0;
                                    w_neg  = ~r_neg;
                                end else begin
                                    w_hcnt = r_hcnt + LEN_W'(1);
                                end
                            end
                            default: begin
                                w_sample = r_acc;
                                w_acc    = r_acc + r_amp;
                            end
                        endcase
                    end
                end else begin
                    w_div = r_div + LEN_W'(1);
                end
            end

            S_FLUSH: begin
                if (w_tick) begin
                    w_div    = '0;
                    w_sample = '0;
                    if (r_fcnt == c_FLUSH_LAST) begin
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_fcnt  = r_fcnt + LEN_W'(1);
                        w_valid = 1'b1;
                        w_idx   = r_idx + LEN_W'(1);
                    end
                end else begin
                    w_div = r_div + LEN_W'(1);
                end
            end

            S_DONE: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end

            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign sample_idx   = r_idx;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
`default_nettype wire
